top_core_soc: RTL and testbench



---
 rtl/top_core_pkg.sv | 32 +++
 rtl/spi_wr_slave.sv | 65 ++++++
 rtl/top_core_soc.sv | 145 ++++++++++++++
 tb/tb_top_core_soc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/top_core_pkg.sv
// top_core_pkg: shared constants, decode fields and address helpers for the SoC core and its SPI loader.
package top_core_pkg;
    localparam int          MEM_WORDS     = 32;
    localparam logic [31:0] MEM_BASE      = 32'h80;
    localparam logic [31:0] GPIO_ADDR     = 32'h1000;
    localparam logic [31:0] BOOT_PC       = 32'h80;
    localparam logic [7:0]  SPI_CMD_WRITE = 8'h02;
    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011
    } opcode_e;
    typedef enum logic [1:0] {SPI_IDLE, SPI_SHIFT, SPI_DONE} spi_state_e;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    // RAM occupies one aligned 128-byte window, so only the upper bits need matching
    function automatic logic in_ram(input logic [31:0] a);
        return a[31:7] == MEM_BASE[31:7];
    endfunction
endpackage

// File: rtl/spi_wr_slave.sv
// spi_wr_slave: mode-0 write-only SPI slave; pins are synced into clk_i and a
// valid 72-bit write frame produces a one-cycle RAM write strobe.
module spi_wr_slave
    import top_core_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sclk_i,
    input  logic        cs_ni,
    input  logic        sdi_i,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o
);
    logic [2:0]  sclk_q;
    logic [1:0]  cs_q, sdi_q;
    logic [6:0]  cnt_q, cnt_d;
    logic [70:0] sr_q, sr_d;
    logic [71:0] frame;
    logic        rise, wr_en_q, wr_en_d;
    spi_state_e  state_q, state_d;

    // sclk_q[2] is the previous synced level, used only for edge detection
    assign rise      = sclk_q[1] & ~sclk_q[2];
    assign frame     = {sr_q, sdi_q[1]};
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = sr_q[63:32];
    assign wr_data_o = sr_q[31:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        wr_en_d = 1'b0;
        if (cs_q[1]) begin
            state_d = SPI_IDLE;
            cnt_d   = '0;
        end else if (rise && state_q != SPI_DONE) begin
            sr_d    = frame[70:0];
            cnt_d   = cnt_q + 7'd1;
            state_d = (cnt_q == 7'd71) ? SPI_DONE : SPI_SHIFT;
            wr_en_d = cnt_q == 7'd71 && frame[71:64] == SPI_CMD_WRITE && in_ram(frame[63:32]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q  <= '0;
            cs_q    <= '1;
            sdi_q   <= '0;
            state_q <= SPI_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            wr_en_q <= 1'b0;
        end else begin
            sclk_q  <= {sclk_q[1:0], sclk_i};
            cs_q    <= {cs_q[0], cs_ni};
            sdi_q   <= {sdi_q[0], sdi_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            wr_en_q <= wr_en_d;
        end
    end
endmodule

// File: rtl/top_core_soc.sv
// top_core_soc: minimal SoC with an SPI-loaded 32-word RAM, a single-cycle
// RV32I-subset core and a memory-mapped GPIO output register.
module top_core_soc
    import top_core_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_enable_i,
    input  logic        en_ifetch_i,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    output logic [1:0]  spi_mode,
    input  logic        spi_sdi0,
    input  logic        spi_sdi1,
    input  logic        spi_sdi2,
    input  logic        spi_sdi3,
    output logic        spi_sdo0,
    output logic        spi_sdo1,
    output logic        spi_sdo2,
    output logic        spi_sdo3,
    output logic [31:0] gpio_o
);
    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] rf_q [32];
    logic [31:0] pc_q, pc_d, gpio_q, gpio_d;
    logic        halted_q, halted_d;
    logic        spi_we;
    logic [31:0] spi_addr, spi_data;
    logic [31:0] instr, rs1, rs2, imm_i, imm_s, imm_b, imm_j;
    logic [31:0] ld_addr, st_addr, ld_data, pc4, rd_val, nxt_pc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        run, bad, wb, is_st, halt, commit, rf_we, ram_we;
    logic        unused_ok;

    spi_wr_slave u_spi (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .sclk_i    (spi_sclk),
        .cs_ni     (spi_cs),
        .sdi_i     (spi_sdi0),
        .wr_en_o   (spi_we),
        .wr_addr_o (spi_addr),
        .wr_data_o (spi_data)
    );

    assign spi_mode  = 2'b00;
    assign spi_sdo0  = 1'b0;
    assign spi_sdo1  = 1'b0;
    assign spi_sdo2  = 1'b0;
    assign spi_sdo3  = 1'b0;
    assign gpio_o    = gpio_q;
    assign unused_ok = ^{spi_sdi1, spi_sdi2, spi_sdi3, spi_addr[31:7], spi_addr[1:0]};

    assign instr   = mem_q[pc_q[6:2]];
    assign rd      = instr[11:7];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign rs1     = (instr[19:15] == 5'd0) ? '0 : rf_q[instr[19:15]];
    assign rs2     = (instr[24:20] == 5'd0) ? '0 : rf_q[instr[24:20]];
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pc4     = pc_q + 32'd4;
    assign ld_addr = rs1 + imm_i;
    assign st_addr = rs1 + imm_s;
    assign ld_data = in_ram(ld_addr) ? mem_q[ld_addr[6:2]] : (ld_addr == GPIO_ADDR) ? gpio_q : '0;

    always_comb begin
        bad    = 1'b0;
        wb     = 1'b0;
        is_st  = 1'b0;
        rd_val = '0;
        nxt_pc = pc4;
        case (instr[6:0])
            OP_LUI: begin
                wb     = 1'b1;
                rd_val = {instr[31:12], 12'h000};
            end
            OP_IMM: begin
                wb     = 1'b1;
                rd_val = (f3 == F3_SLL) ? rs1 << instr[24:20] : rs1 + imm_i;
                bad    = !(f3 == F3_ADD || (f3 == F3_SLL && f7 == F7_BASE));
            end
            OP_REG: begin
                wb     = 1'b1;
                rd_val = (f7 == F7_ALT) ? rs1 - rs2 : (f3 == F3_XOR) ? rs1 ^ rs2 :
                         (f3 == F3_OR) ? rs1 | rs2 : (f3 == F3_AND) ? rs1 & rs2 : rs1 + rs2;
                bad    = (f7 == F7_ALT) ? f3 != F3_ADD :
                         !(f7 == F7_BASE && f3 inside {F3_ADD, F3_XOR, F3_OR, F3_AND});
            end
            OP_BRANCH: begin
                nxt_pc = ((rs1 == rs2) ^ (f3 == F3_BNE)) ? pc_q + imm_b : pc4;
                bad    = !(f3 == F3_BEQ || f3 == F3_BNE);
            end
            OP_JAL: begin
                wb     = 1'b1;
                rd_val = pc4;
                nxt_pc = pc_q + imm_j;
            end
            OP_LOAD: begin
                wb     = 1'b1;
                rd_val = ld_data;
                bad    = f3 != F3_W;
            end
            OP_STORE: begin
                is_st = 1'b1;
                bad   = f3 != F3_W;
            end
            default: bad = 1'b1;
        endcase
    end

    // a halting instruction only sets the sticky flag; nothing else commits
    assign run      = fetch_enable_i & en_ifetch_i & ~halted_q;
    assign halt     = !in_ram(pc_q) || bad;
    assign commit   = run & ~halt;
    assign pc_d     = commit ? nxt_pc : pc_q;
    assign halted_d = halted_q | (run & halt);
    assign gpio_d   = (commit && is_st && st_addr == GPIO_ADDR) ? rs2 : gpio_q;
    assign rf_we    = commit && wb && rd != 5'd0;
    assign ram_we   = commit && is_st && in_ram(st_addr);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= BOOT_PC;
            gpio_q   <= '0;
            halted_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            gpio_q   <= gpio_d;
            halted_q <= halted_d;
            if (rf_we) rf_q[rd] <= rd_val;
        end
    end

    // SPI loader has priority over a core store landing in the same cycle
    always_ff @(posedge clk_i) begin
        if (spi_we) mem_q[spi_addr[6:2]] <= spi_data;
        else if (ram_we) mem_q[st_addr[6:2]] <= rs2;
    end
endmodule

// File: tb/tb_top_core_soc.sv
// tb_top_core_soc: directed bench; loads programs over SPI, runs the core and checks GPIO/PC/halt.
module tb_top_core_soc;
    logic        clk_i = 1'b0, rst_ni = 1'b0, fetch_enable_i = 1'b0, en_ifetch_i = 1'b0;
    logic        spi_sclk = 1'b0, spi_cs = 1'b1;
    logic        spi_sdi0 = 1'b0, spi_sdi1 = 1'b0, spi_sdi2 = 1'b0, spi_sdi3 = 1'b0;
    logic [1:0]  spi_mode;
    logic        spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3;
    logic [31:0] gpio_o;
    logic [31:0] prog [32];
    int          passes = 0, fails = 0, total = 0;
    localparam logic [6:0] OPI = 7'h13, OPL = 7'h03;

    always #5 clk_i = ~clk_i;

    top_core_soc dut (
        .clk_i (clk_i), .rst_ni (rst_ni), .fetch_enable_i (fetch_enable_i), .en_ifetch_i (en_ifetch_i),
        .spi_sclk (spi_sclk), .spi_cs (spi_cs), .spi_mode (spi_mode),
        .spi_sdi0 (spi_sdi0), .spi_sdi1 (spi_sdi1), .spi_sdi2 (spi_sdi2), .spi_sdi3 (spi_sdi3),
        .spi_sdo0 (spi_sdo0), .spi_sdo1 (spi_sdo1), .spi_sdo2 (spi_sdo2), .spi_sdo3 (spi_sdo3),
        .gpio_o (gpio_o)
    );

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data, input int n);
        logic [71:0] f;
        f = {cmd, addr, data};
        spi_cs = 1'b0;
        tick(4);
        for (int i = 0; i < n; i++) begin
            spi_sdi0 = f[71-i];
            spi_sclk = 1'b0;
            tick(4);
            spi_sclk = 1'b1;
            tick(4);
        end
        spi_sclk = 1'b0;
        tick(4);
        spi_cs = 1'b1;
        tick(6);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) spi_frame(8'h02, 32'h80 + 32'(i * 4), prog[i], 72);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick(2);
        rst_ni = 1'b1;
        tick(1);
    endtask

    task automatic run_core(input logic fe, input logic ie, input int n);
        fetch_enable_i = fe;
        en_ifetch_i    = ie;
        tick(n);
    endtask

    initial begin
        tick(2);
        chk("rst_gpio", gpio_o, 32'h0);
        chk("rst_pc", dut.pc_q, 32'h80);
        chk("rst_halted", {31'd0, dut.halted_q}, 32'h0);
        chk("spi_mode", {30'd0, spi_mode}, 32'h0);
        chk("spi_sdo", {28'd0, spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0}, 32'h0);
        rst_ni = 1'b1;
        tick(1);
        // addi x1,x0,30 ; lui x2,1 ; sw x1,0(x2) ; halt
        prog[0] = 32'h01E00093; prog[1] = 32'h00001137; prog[2] = 32'h00112023; prog[3] = 32'h00000FFF;
        load(4);
        chk("load_w0", dut.mem_q[0], 32'h01E00093);
        chk("load_w3", dut.mem_q[3], 32'h00000FFF);
        run_core(1'b0, 1'b1, 10);
        chk("fe_low_pc", dut.pc_q, 32'h80);
        chk("fe_low_gpio", gpio_o, 32'h0);
        run_core(1'b1, 1'b0, 10);
        chk("if_low_pc", dut.pc_q, 32'h80);
        chk("if_low_gpio", gpio_o, 32'h0);
        fetch_enable_i = 1'b0;
        spi_frame(8'h03, 32'h80, 32'h00000FFF, 72);
        spi_frame(8'h02, 32'h200, 32'h00000FFF, 72);
        spi_frame(8'h02, 32'h84, 32'hDEADBEEF, 40);
        spi_frame(8'h02, 32'hD0, 32'hCAFEF00D, 72);
        chk("bad_cmd_w0", dut.mem_q[0], 32'h01E00093);
        chk("abort_w1", dut.mem_q[1], 32'h00001137);
        chk("after_abort_w20", dut.mem_q[20], 32'hCAFEF00D);
        run_core(1'b1, 1'b1, 10);
        chk("p1_gpio", gpio_o, 32'd30);
        chk("p1_pc", dut.pc_q, 32'h8C);
        chk("p1_halted", {31'd0, dut.halted_q}, 32'h1);
        run_core(1'b0, 1'b0, 5);
        chk("p1_hold_gpio", gpio_o, 32'd30);
        // addi x2,x0,5 ; lui x3,1 ; addi x1,x1,1 ; sw x1,0(x3) ; bne x1,x2,-8 ; halt
        prog[0] = 32'h00500113; prog[1] = 32'h000011B7; prog[2] = 32'h00108093;
        prog[3] = 32'h0011A023; prog[4] = 32'hFE209CE3; prog[5] = 32'h00000FFF;
        do_reset();
        load(6);
        run_core(1'b1, 1'b1, 8);
        chk("p2_mid_gpio", gpio_o, 32'd2);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_gpio", gpio_o, 32'h0);
        chk("async_rst_pc", dut.pc_q, 32'h80);
        tick(1);
        rst_ni = 1'b1;
        tick(40);
        chk("p2_gpio", gpio_o, 32'd5);
        chk("p2_pc", dut.pc_q, 32'h94);
        chk("p2_halted", {31'd0, dut.halted_q}, 32'h1);
        fetch_enable_i = 1'b0;
        prog[0]  = i_t(12'd12, 5'd0, 3'd0, 5'd1, OPI);
        prog[1]  = i_t(12'd10, 5'd0, 3'd0, 5'd2, OPI);
        prog[2]  = r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        prog[3]  = r_t(7'h20, 5'd1, 5'd2, 3'd0, 5'd4);
        prog[4]  = r_t(7'h00, 5'd2, 5'd1, 3'd4, 5'd5);
        prog[5]  = r_t(7'h00, 5'd2, 5'd1, 3'd6, 5'd6);
        prog[6]  = r_t(7'h00, 5'd2, 5'd1, 3'd7, 5'd7);
        prog[7]  = i_t(12'd4, 5'd7, 3'd1, 5'd8, OPI);
        prog[8]  = {20'h00001, 5'd9, 7'h37};
        prog[9]  = s_t(12'd0, 5'd4, 5'd9);
        prog[10] = i_t(12'd0, 5'd9, 3'd2, 5'd10, OPL);
        prog[11] = s_t(12'd124, 5'd3, 5'd8);
        prog[12] = i_t(12'd124, 5'd8, 3'd2, 5'd11, OPL);
        prog[13] = b_t(13'd8, 5'd3, 5'd11, 3'd0);
        prog[14] = i_t(12'd99, 5'd0, 3'd0, 5'd5, OPI);
        prog[15] = j_t(21'd8, 5'd12);
        prog[16] = i_t(12'd77, 5'd0, 3'd0, 5'd5, OPI);
        prog[17] = r_t(7'h00, 5'd6, 5'd5, 3'd0, 5'd13);
        prog[18] = r_t(7'h00, 5'd7, 5'd13, 3'd0, 5'd13);
        prog[19] = r_t(7'h00, 5'd10, 5'd13, 3'd0, 5'd13);
        prog[20] = r_t(7'h00, 5'd12, 5'd13, 3'd0, 5'd13);
        prog[21] = r_t(7'h00, 5'd11, 5'd13, 3'd0, 5'd13);
        prog[22] = r_t(7'h00, 5'd8, 5'd13, 3'd0, 5'd13);
        prog[23] = i_t(12'd0, 5'd0, 3'd2, 5'd14, OPL);
        prog[24] = r_t(7'h00, 5'd14, 5'd13, 3'd0, 5'd13);
        prog[25] = s_t(12'd0, 5'd13, 5'd9);
        prog[26] = 32'h00000FFF;
        do_reset();
        load(27);
        run_core(1'b1, 1'b1, 10);
        chk("p3_sub_gpio", gpio_o, 32'hFFFFFFFE);
        tick(50);
        chk("p3_gpio", gpio_o, 32'h170);
        chk("p3_pc", dut.pc_q, 32'hE8);
        chk("p3_ram_store", dut.mem_q[31], 32'd22);
        chk("p3_halted", {31'd0, dut.halted_q}, 32'h1);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
